// File: rtl/aha_xgcd_axim_pkg.sv
`default_nettype none
// ============================================================================
// aha_xgcd_axim_pkg : states, AXI constants and STATUS codes for the XGCD master
// Revision: 1.0
// ============================================================================
package aha_xgcd_axim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_FIN  = 3'd6
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [3:0] CACHE_DEF  = 4'b0011;
  localparam logic [2:0] PROT_DEF   = 3'b000;

  localparam logic [1:0] STAT_OKAY   = 2'b00;
  localparam logic [1:0] STAT_SLVERR = 2'b10;
  localparam logic [1:0] STAT_DECERR = 2'b01;
  localparam logic [1:0] STAT_ERR    = 2'b11;

  // EXOKAY is unexpected for a non-exclusive master, so it reports as a local error
  function automatic logic [1:0] resp_to_status(input logic [1:0] resp);
    case (resp)
      RESP_OKAY:   resp_to_status = STAT_OKAY;
      RESP_EXOKAY: resp_to_status = STAT_ERR;
      RESP_SLVERR: resp_to_status = STAT_SLVERR;
      default:     resp_to_status = STAT_DECERR;
    endcase
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, b};
    sat_add16 = sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/aha_xgcd_axim_beat_ctr.sv
`default_nettype none
// ============================================================================
// aha_xgcd_axim_beat_ctr : 8-bit burst beat counter, last = (cnt == len)
// Revision: 1.0
// ============================================================================
module aha_xgcd_axim_beat_ctr (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       load_i,
  input  logic [7:0] len_i,
  input  logic       inc_i,
  output logic [7:0] len_o,
  output logic       last_o
);

  logic [7:0] cnt_q;
  logic [7:0] len_q;

  // Holding at last keeps a 256-beat burst from wrapping back to zero
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      cnt_q <= 8'd0;
      len_q <= 8'd0;
    end else if (load_i) begin
      cnt_q <= 8'd0;
      len_q <= len_i;
    end else if (inc_i && !last_o) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign len_o  = len_q;
  assign last_o = (cnt_q == len_q);

endmodule
`default_nettype wire

// File: rtl/aha_xgcd_axi_master.sv
`default_nettype none
// ============================================================================
// aha_xgcd_axi_master : single-outstanding AXI4 burst master for an XGCD data port
// Optional AHA_XGCD_AXIM_PERF_EN adds LAST_CYCLES (command accept..DONE count)
// Revision: 1.0
// ============================================================================
module aha_xgcd_axi_master
  import aha_xgcd_axim_pkg::*;
#(
  parameter logic [3:0]  AXI_ID = 4'h0,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [7:0]        cmd_len_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [63:0]       wr_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [63:0]       rd_data_o,
  output logic              rd_last_o,
  output logic              done_o,
  output logic [1:0]        status_o,
`ifdef AHA_XGCD_AXIM_PERF_EN
  output logic [15:0]       last_cycles_o,
`endif
  output logic [3:0]        m_axi_awid_o,
  output logic [ADDR_W-1:0] m_axi_awaddr_o,
  output logic [7:0]        m_axi_awlen_o,
  output logic [2:0]        m_axi_awsize_o,
  output logic [1:0]        m_axi_awburst_o,
  output logic              m_axi_awlock_o,
  output logic [3:0]        m_axi_awcache_o,
  output logic [2:0]        m_axi_awprot_o,
  output logic              m_axi_awvalid_o,
  input  logic              m_axi_awready_i,
  output logic [63:0]       m_axi_wdata_o,
  output logic [7:0]        m_axi_wstrb_o,
  output logic              m_axi_wlast_o,
  output logic              m_axi_wvalid_o,
  input  logic              m_axi_wready_i,
  input  logic [3:0]        m_axi_bid_i,
  input  logic [1:0]        m_axi_bresp_i,
  input  logic              m_axi_bvalid_i,
  output logic              m_axi_bready_o,
  output logic [3:0]        m_axi_arid_o,
  output logic [ADDR_W-1:0] m_axi_araddr_o,
  output logic [7:0]        m_axi_arlen_o,
  output logic [2:0]        m_axi_arsize_o,
  output logic [1:0]        m_axi_arburst_o,
  output logic              m_axi_arlock_o,
  output logic [3:0]        m_axi_arcache_o,
  output logic [2:0]        m_axi_arprot_o,
  output logic              m_axi_arvalid_o,
  input  logic              m_axi_arready_i,
  input  logic [3:0]        m_axi_rid_i,
  input  logic [63:0]       m_axi_rdata_i,
  input  logic [1:0]        m_axi_rresp_i,
  input  logic              m_axi_rlast_i,
  input  logic              m_axi_rvalid_i,
  output logic              m_axi_rready_o
);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              cross_q;
  logic              cmd_ready_q;
  logic              awvalid_q;
  logic              arvalid_q;
  logic              bready_q;
  logic              done_q;
  logic [1:0]        status_q;

  logic        accept;
  logic        cross_4k;
  logic [12:0] end_off;
  logic        w_hs;
  logic        r_hs;
  logic        last;
  logic [7:0]  len;
  logic        go_fin;

  assign accept = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid_i;

  // Byte offset just past the burst within its 4 KB page; equal to 4096 is still legal
  assign end_off  = {1'b0, cmd_addr_i[11:3], 3'b000} + {2'b00, cmd_len_i, 3'b000} + 13'd8;
  assign cross_4k = (end_off > 13'd4096);

  assign w_hs = (state_q == ST_W) && wr_valid_i && m_axi_wready_i;
  assign r_hs = (state_q == ST_R) && m_axi_rvalid_i && rd_ready_i;

  assign go_fin = (((state_q == ST_AW) || (state_q == ST_AR)) && cross_q)
                || ((state_q == ST_B) && m_axi_bvalid_i)
                || (r_hs && last);

  aha_xgcd_axim_beat_ctr u_beat_ctr (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .load_i   (accept),
    .len_i    (cmd_len_i),
    .inc_i    (w_hs || r_hs),
    .len_o    (len),
    .last_o   (last)
  );

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cross_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= STAT_OKAY;
    end else begin
      done_q <= go_fin;
      unique case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= cmd_addr_i & {{(ADDR_W-3){1'b1}}, 3'b000};
            cross_q     <= cross_4k;
            status_q    <= STAT_OKAY;
            if (cmd_write_i) begin
              state_q   <= ST_AW;
              awvalid_q <= !cross_4k;
            end else begin
              state_q   <= ST_AR;
              arvalid_q <= !cross_4k;
            end
          end
        end
        ST_AW: begin
          if (cross_q) begin
            state_q  <= ST_FIN;
            status_q <= STAT_ERR;
          end else if (m_axi_awready_i) begin
            awvalid_q <= 1'b0;
            state_q   <= ST_W;
          end
        end
        ST_W: begin
          if (w_hs && last) begin
            state_q  <= ST_B;
            bready_q <= 1'b1;
          end
        end
        ST_B: begin
          if (m_axi_bvalid_i) begin
            bready_q <= 1'b0;
            state_q  <= ST_FIN;
            status_q <= (m_axi_bid_i != AXI_ID) ? STAT_ERR : resp_to_status(m_axi_bresp_i);
          end
        end
        ST_AR: begin
          if (cross_q) begin
            state_q  <= ST_FIN;
            status_q <= STAT_ERR;
          end else if (m_axi_arready_i) begin
            arvalid_q <= 1'b0;
            state_q   <= ST_R;
          end
        end
        ST_R: begin
          if (r_hs) begin
            // Protocol errors override any latched response; otherwise keep the first non-OKAY
            if ((m_axi_rid_i != AXI_ID) || (m_axi_rlast_i != last)) begin
              status_q <= STAT_ERR;
            end else if (status_q == STAT_OKAY) begin
              status_q <= resp_to_status(m_axi_rresp_i);
            end
            if (last) begin
              state_q <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef AHA_XGCD_AXIM_PERF_EN
  logic [15:0] cyc_q;
  logic [15:0] last_cycles_q;

  // cyc_q counts cycles since accept; +2 covers the cycle entering FIN and the DONE cycle
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      cyc_q         <= 16'd0;
      last_cycles_q <= 16'd0;
    end else if (accept) begin
      cyc_q <= 16'd1;
    end else if ((state_q != ST_IDLE) && (state_q != ST_FIN)) begin
      cyc_q <= sat_add16(cyc_q, 2'd1);
      if (go_fin) begin
        last_cycles_q <= sat_add16(cyc_q, 2'd2);
      end
    end
  end

  assign last_cycles_o = last_cycles_q;
`endif

  assign cmd_ready_o = cmd_ready_q;
  assign done_o      = done_q;
  assign status_o    = status_q;

  assign m_axi_awid_o    = AXI_ID;
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awlen_o   = len;
  assign m_axi_awsize_o  = SIZE_8B;
  assign m_axi_awburst_o = BURST_INCR;
  assign m_axi_awlock_o  = 1'b0;
  assign m_axi_awcache_o = CACHE_DEF;
  assign m_axi_awprot_o  = PROT_DEF;
  assign m_axi_awvalid_o = awvalid_q;

  assign m_axi_wdata_o  = wr_data_i;
  assign m_axi_wstrb_o  = 8'hFF;
  assign m_axi_wlast_o  = last;
  assign m_axi_wvalid_o = (state_q == ST_W) && wr_valid_i;
  assign wr_ready_o     = (state_q == ST_W) && m_axi_wready_i;

  assign m_axi_bready_o = bready_q;

  assign m_axi_arid_o    = AXI_ID;
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arlen_o   = len;
  assign m_axi_arsize_o  = SIZE_8B;
  assign m_axi_arburst_o = BURST_INCR;
  assign m_axi_arlock_o  = 1'b0;
  assign m_axi_arcache_o = CACHE_DEF;
  assign m_axi_arprot_o  = PROT_DEF;
  assign m_axi_arvalid_o = arvalid_q;

  assign rd_valid_o     = (state_q == ST_R) && m_axi_rvalid_i;
  assign m_axi_rready_o = (state_q == ST_R) && rd_ready_i;
  assign rd_data_o      = m_axi_rdata_i;
  assign rd_last_o      = last;

endmodule
`default_nettype wire

// File: tb/tb_aha_xgcd_axi_master.sv
`default_nettype none
// ============================================================================
// tb_aha_xgcd_axi_master : directed self-checking bench for aha_xgcd_axi_master
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_aha_xgcd_axi_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [63:0] wr_data = '0;
  logic        rd_valid, rd_ready = 1'b0, rd_last;
  logic [63:0] rd_data;
  logic        done;
  logic [1:0]  status;
`ifdef AHA_XGCD_AXIM_PERF_EN
  logic [15:0] last_cycles;
  int          bcyc;
`endif
  logic [3:0]  awid, arid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst;
  logic        awlock, arlock;
  logic [3:0]  awcache, arcache;
  logic        awvalid, arvalid, awready = 1'b0, arready = 1'b0;
  logic [63:0] wdata;
  logic        wlast, wvalid, wready = 1'b0;
  logic [3:0]  bid = '0, rid = '0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready;
  logic [63:0] rdata = '0;
  logic        rlast = 1'b0, rvalid = 1'b0, rready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aha_xgcd_axi_master dut (
    .clk_i(clk), .resetn_i(resetn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data), .rd_last_o(rd_last),
    .done_o(done), .status_o(status),
`ifdef AHA_XGCD_AXIM_PERF_EN
    .last_cycles_o(last_cycles),
`endif
    .m_axi_awid_o(awid), .m_axi_awaddr_o(awaddr), .m_axi_awlen_o(awlen),
    .m_axi_awsize_o(awsize), .m_axi_awburst_o(awburst), .m_axi_awlock_o(awlock),
    .m_axi_awcache_o(awcache), .m_axi_awprot_o(awprot), .m_axi_awvalid_o(awvalid),
    .m_axi_awready_i(awready),
    .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast),
    .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
    .m_axi_bid_i(bid), .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready),
    .m_axi_arid_o(arid), .m_axi_araddr_o(araddr), .m_axi_arlen_o(arlen),
    .m_axi_arsize_o(arsize), .m_axi_arburst_o(arburst), .m_axi_arlock_o(arlock),
    .m_axi_arcache_o(arcache), .m_axi_arprot_o(arprot), .m_axi_arvalid_o(arvalid),
    .m_axi_arready_i(arready),
    .m_axi_rid_i(rid), .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp),
    .m_axi_rlast_i(rlast), .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] resp, input logic [3:0] id,
                          input logic [1:0] exp_st, input bit stall);
    logic [31:0] exp_addr;
    exp_addr  = addr & 32'hFFFF_FFF8;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len;
    #1;
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_awvalid"}, awvalid, 1'b1);
    chk({tag, "_awaddr"}, awaddr, exp_addr);
    chk({tag, "_awlen"}, awlen, len);
    chk({tag, "_awfields"}, {awid, awsize, awburst, awlock, awcache, awprot},
        {4'h0, 3'b011, 2'b01, 1'b0, 4'b0011, 3'b000});
    chk({tag, "_w_before_aw"}, wvalid, 1'b0);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk({tag, "_aw_drop"}, awvalid, 1'b0);
    wr_valid = 1'b1; wready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      if (stall && i == 1) begin
        wr_valid = 1'b0;
        #1;
        chk({tag, "_wstall"}, wvalid, 1'b0);
        tick();
        wr_valid = 1'b1;
      end
      wr_data = 64'hA0 + 64'(i);
      #1;
      chk({tag, "_wvalid"}, wvalid, 1'b1);
      chk({tag, "_wdata"}, wdata, 64'hA0 + 64'(i));
      chk({tag, "_wlast"}, wlast, (i == int'(len)));
      chk({tag, "_wr_ready"}, wr_ready, 1'b1);
      chk({tag, "_wstrb"}, wstrb, 8'hFF);
      tick();
    end
    wr_valid = 1'b0; wready = 1'b0;
    chk({tag, "_bready"}, bready, 1'b1);
    chk({tag, "_done_early"}, done, 1'b0);
    bvalid = 1'b1; bresp = resp; bid = id;
    tick();
    bvalid = 1'b0; bresp = 2'b00; bid = 4'h0;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_status"}, status, exp_st);
    chk({tag, "_cmd_ready_fin"}, cmd_ready, 1'b0);
    tick();
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_cmd_ready_idle"}, cmd_ready, 1'b1);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                         input int err_beat, input int last_beat, input bit toggle,
                         input logic [1:0] exp_st);
    int beat;
    int cyc;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
    #1;
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_arvalid"}, arvalid, 1'b1);
    chk({tag, "_araddr"}, araddr, addr & 32'hFFFF_FFF8);
    chk({tag, "_arlen"}, arlen, len);
    chk({tag, "_awvalid"}, awvalid, 1'b0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk({tag, "_ar_drop"}, arvalid, 1'b0);
    beat = 0; cyc = 0;
    rvalid = 1'b1;
    while (beat <= int'(len) && cyc < 600) begin
      rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      rdata    = 64'h5000 + 64'(beat);
      rresp    = (beat == err_beat) ? 2'b10 : 2'b00;
      rlast    = (beat == last_beat);
      #1;
      chk({tag, "_rd_valid"}, rd_valid, 1'b1);
      chk({tag, "_rd_data"}, rd_data, 64'h5000 + 64'(beat));
      chk({tag, "_rd_last"}, rd_last, (beat == int'(len)));
      chk({tag, "_rready"}, rready, rd_ready);
      if (rd_ready) beat++;
      cyc++;
      tick();
    end
    rvalid = 1'b0; rd_ready = 1'b0; rlast = 1'b0; rresp = 2'b00;
    chk({tag, "_beats"}, 64'(beat), 64'(int'(len) + 1));
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_status"}, status, exp_st);
    tick();
    chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_valids", {awvalid, arvalid, wvalid, rd_valid, bready, rready}, 6'b0);
    chk("rst_done_status", {done, status}, 3'b000);
    chk("rst_addr_len", {awaddr, awlen}, 40'h0);
`ifdef AHA_XGCD_AXIM_PERF_EN
    chk("rst_last_cycles", last_cycles, 16'h0);
`endif
    resetn = 1'b1;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // Basic write, mid-burst WR_VALID stall, OKAY
    do_write("t1", 32'h0000_0100, 8'd3, 2'b00, 4'h0, 2'b00, 1'b1);
    // Burst ending exactly at the 4 KB boundary is legal; DECERR maps to 01
    do_write("edge4k", 32'h0000_0FF0, 8'd1, 2'b11, 4'h0, 2'b01, 1'b0);
    // Unaligned address gets its low bits cleared; wrong BID forces 11
    do_write("bid", 32'h0000_0027, 8'd0, 2'b00, 4'h3, 2'b11, 1'b0);

    // Read with SLVERR on beat 2 and toggling RD_READY
    do_read("t2", 32'h0000_0200, 8'd7, 2, 7, 1'b1, 2'b10);

    // 4 KB crossing write: no AXI traffic, DONE two cycles after accept
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0FF8; cmd_len = 8'd1;
    awready = 1'b1;
    #1;
    chk("t3_cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("t3_c1", {awvalid, done}, 2'b00);
    tick();
    chk("t3_c2_awvalid", awvalid, 1'b0);
    chk("t3_c2_done", done, 1'b1);
    chk("t3_c2_status", status, 2'b11);
    awready = 1'b0;
    tick();
    chk("t3_c3", {done, cmd_ready}, 2'b01);

    // Early RLAST on beat 1: all beats forwarded, protocol error reported
    do_read("t4", 32'h0000_0300, 8'd3, -1, 1, 1'b0, 2'b11);

    // Reset during W beat 2 of a 6-beat write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0500; cmd_len = 8'd5;
    tick();
    cmd_valid = 1'b0; awready = 1'b1;
    tick();
    awready = 1'b0;
    wr_valid = 1'b1; wready = 1'b1;
    tick();
    tick();
    chk("t5_beat2_wvalid", wvalid, 1'b1);
    chk("t5_beat2_wlast", wlast, 1'b0);
    resetn = 1'b0;
    tick();
    chk("t5_rst_valids", {awvalid, arvalid, wvalid, rd_valid, bready, rready}, 6'b0);
    chk("t5_rst_done_ready", {done, cmd_ready}, 2'b00);
    resetn = 1'b1; wr_valid = 1'b0; wready = 1'b0;
    tick();
    chk("t5_release_cmd_ready", cmd_ready, 1'b1);
    do_write("t5b", 32'h0000_0040, 8'd0, 2'b00, 4'h0, 2'b00, 1'b0);

`ifdef AHA_XGCD_AXIM_PERF_EN
    // LEN=0 read, ARREADY two cycles late, RVALID three cycles later
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0080; cmd_len = 8'd0;
    bcyc = 1;
    tick(); bcyc++;
    cmd_valid = 1'b0;
    repeat (2) begin tick(); bcyc++; end
    arready = 1'b1;
    tick(); bcyc++;
    arready = 1'b0;
    repeat (3) begin tick(); bcyc++; end
    rvalid = 1'b1; rlast = 1'b1; rd_ready = 1'b1; rdata = 64'h77;
    tick(); bcyc++;
    rvalid = 1'b0; rlast = 1'b0; rd_ready = 1'b0;
    chk("t6_done", done, 1'b1);
    chk("t6_last_cycles", last_cycles, 16'(bcyc));
    tick();

    // Long ARREADY stall saturates the counter
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0080; cmd_len = 8'd0;
    tick();
    cmd_valid = 1'b0;
    repeat (70000) tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rd_ready = 1'b1;
    tick();
    rvalid = 1'b0; rlast = 1'b0; rd_ready = 1'b0;
    chk("t6_sat_done", done, 1'b1);
    chk("t6_sat_last_cycles", last_cycles, 16'hFFFF);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
